// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control encodings: ALUOp classes, ALU operations, load and branch types.
// Also consumed by the ALU and branch unit, so the values here are architectural.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_ARITH  = 2'b10,
    ALUOP_JUMP   = 2'b11
  } aluop_e;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SLL  = 4'b0011,
    OP_SRA  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_XOR  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_BGE  = 4'b1010,
    OP_BGEU = 4'b1011,
    OP_BLT  = 4'b1100,
    OP_BLTU = 4'b1101
  } operation_e;

  typedef enum logic [2:0] {
    LD_NONE = 3'b000,
    LD_LH   = 3'b001,
    LD_LW   = 3'b010,
    LD_LBU  = 3'b100,
    LD_LHU  = 3'b101,
    LD_LB   = 3'b111
  } load_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BNE  = 3'b001,
    BR_BEQ  = 3'b010,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } branch_e;

  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

endpackage

// File: rtl/alu_ctrl_stage_decode.sv
// Purely combinational ALU control decode from ALUOp/Funct7/Funct3.
// Every unlisted combination falls through to AND with zero load/branch types.
module alu_decode
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned M_EXT = 1
) (
  input  logic [1:0] alu_op,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output operation_e operation,
  output load_e      load_type,
  output branch_e    branch_type,
  output logic       muldiv_en,
  output logic [2:0] muldiv_op
);

  always_comb begin
    operation   = OP_AND;
    load_type   = LD_NONE;
    branch_type = BR_NONE;
    muldiv_en   = 1'b0;
    muldiv_op   = '0;
    case (aluop_e'(alu_op))
      ALUOP_MEM: begin
        operation = OP_ADD;
        case (funct3)
          3'b000:  load_type = LD_LB;
          3'b001:  load_type = LD_LH;
          3'b010:  load_type = LD_LW;
          3'b100:  load_type = LD_LBU;
          3'b101:  load_type = LD_LHU;
          default: load_type = LD_NONE;
        endcase
      end
      ALUOP_BRANCH: begin
        case (funct3)
          3'b000:  begin operation = OP_SUB;  branch_type = BR_BEQ;  end
          3'b001:  begin operation = OP_SUB;  branch_type = BR_BNE;  end
          3'b100:  begin operation = OP_BLT;  branch_type = BR_BLT;  end
          3'b101:  begin operation = OP_BGE;  branch_type = BR_BGE;  end
          3'b110:  begin operation = OP_BLTU; branch_type = BR_BLTU; end
          3'b111:  begin operation = OP_BGEU; branch_type = BR_BGEU; end
          default: ;
        endcase
      end
      ALUOP_ARITH: begin
        if (M_EXT != 0 && funct7 == F7_MEXT) begin
          muldiv_en = 1'b1;
          muldiv_op = funct3;
        end else begin
          case (funct3)
            3'b000:  operation = (funct7 == F7_ALT) ? OP_SUB : OP_ADD;
            3'b001:  operation = OP_SLL;
            3'b010:  operation = OP_SLT;
            3'b011:  operation = OP_SLTU;
            3'b100:  operation = OP_XOR;
            3'b101:  operation = (funct7 == F7_ALT) ? OP_SRA : OP_SRL;
            3'b110:  operation = OP_OR;
            3'b111:  operation = OP_AND;
            default: operation = OP_AND;
          endcase
        end
      end
      ALUOP_JUMP: operation = OP_ADD;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_stage.sv
// ALU control pipeline stage: valid/ready handshake, registered decode, and a
// down-counter that holds off out_valid for multi-cycle MUL/DIV operations.
module alu_ctrl_stage
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned M_EXT   = 1,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] ALUOp,
  input  logic [6:0] Funct7,
  input  logic [2:0] Funct3,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] Operation,
  output logic [2:0] Load_Type,
  output logic [2:0] Branch_Type,
  output logic       MulDiv_En,
  output logic [2:0] MulDiv_Op,
  output logic       Busy
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_M1 = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV_LAT - 1);

  operation_e       dec_operation;
  load_e            dec_load_type;
  branch_e          dec_branch_type;
  logic             dec_muldiv_en;
  logic [2:0]       dec_muldiv_op;
  logic             accept;
  logic             multi;
  logic [CNT_W-1:0] lat_m1;
  logic [CNT_W-1:0] cnt;

  alu_decode #(.M_EXT(M_EXT)) u_decode (
    .alu_op      (ALUOp),
    .funct7      (Funct7),
    .funct3      (Funct3),
    .operation   (dec_operation),
    .load_type   (dec_load_type),
    .branch_type (dec_branch_type),
    .muldiv_en   (dec_muldiv_en),
    .muldiv_op   (dec_muldiv_op)
  );

  // A latency of 1 collapses to the single-cycle path, so Busy never rises for it.
  always_comb begin
    in_ready = (!out_valid || out_ready) && !Busy && !flush && !reset;
    accept   = in_valid && in_ready;
    lat_m1   = '0;
    if (dec_muldiv_en) lat_m1 = Funct3[2] ? DIV_M1 : MUL_M1;
    multi    = dec_muldiv_en && (lat_m1 != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      Busy        <= 1'b0;
      cnt         <= '0;
      Operation   <= '0;
      Load_Type   <= '0;
      Branch_Type <= '0;
      MulDiv_En   <= 1'b0;
      MulDiv_Op   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      Busy      <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      Operation   <= dec_operation;
      Load_Type   <= dec_load_type;
      Branch_Type <= dec_branch_type;
      MulDiv_En   <= dec_muldiv_en;
      MulDiv_Op   <= dec_muldiv_op;
      if (multi) begin
        out_valid <= 1'b0;
        Busy      <= 1'b1;
        cnt       <= lat_m1;
      end else begin
        out_valid <= 1'b1;
      end
    end else if (Busy) begin
      if (cnt == '0) begin
        Busy      <= 1'b0;
        out_valid <= 1'b1;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed-vector bench for alu_ctrl_stage with hand-computed expectations.
// A second instance built without the M extension checks the base-op fallback.
module tb_alu_ctrl_stage;

  logic       clk = 1'b0;
  logic       reset, flush, in_valid, out_ready;
  logic [1:0] ALUOp;
  logic [6:0] Funct7;
  logic [2:0] Funct3;

  logic       in_ready, out_valid, MulDiv_En, Busy;
  logic [3:0] Operation;
  logic [2:0] Load_Type, Branch_Type, MulDiv_Op;

  logic       b_in_ready, b_out_valid, b_MulDiv_En, b_Busy;
  logic [3:0] b_Operation;
  logic [2:0] b_Load_Type, b_Branch_Type, b_MulDiv_Op;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_ctrl_stage #(.M_EXT(1), .MUL_LAT(3), .DIV_LAT(8)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .out_valid(out_valid),
    .out_ready(out_ready), .Operation(Operation), .Load_Type(Load_Type),
    .Branch_Type(Branch_Type), .MulDiv_En(MulDiv_En), .MulDiv_Op(MulDiv_Op), .Busy(Busy)
  );

  alu_ctrl_stage #(.M_EXT(0), .MUL_LAT(3), .DIV_LAT(8)) u_dut_base (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .out_valid(b_out_valid),
    .out_ready(out_ready), .Operation(b_Operation), .Load_Type(b_Load_Type),
    .Branch_Type(b_Branch_Type), .MulDiv_En(b_MulDiv_En), .MulDiv_Op(b_MulDiv_Op),
    .Busy(b_Busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7);
    ALUOp    = aop;
    Funct3   = f3;
    Funct7   = f7;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [1:0] aop;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] op;
    logic [2:0] lt;
    logic [2:0] bt;
  } vec_t;

  vec_t tbl [25];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{2'b10, 3'b000, 7'b0100000, 4'b0110, 3'b000, 3'b000};
    tbl[1]  = '{2'b00, 3'b100, 7'b0000000, 4'b0010, 3'b100, 3'b000};
    tbl[2]  = '{2'b01, 3'b111, 7'b0000000, 4'b1011, 3'b000, 3'b111};
    tbl[3]  = '{2'b10, 3'b000, 7'b0000000, 4'b0010, 3'b000, 3'b000};
    tbl[4]  = '{2'b10, 3'b001, 7'b0000000, 4'b0011, 3'b000, 3'b000};
    tbl[5]  = '{2'b10, 3'b010, 7'b0000000, 4'b1000, 3'b000, 3'b000};
    tbl[6]  = '{2'b10, 3'b011, 7'b0000000, 4'b1001, 3'b000, 3'b000};
    tbl[7]  = '{2'b10, 3'b100, 7'b0000000, 4'b0111, 3'b000, 3'b000};
    tbl[8]  = '{2'b10, 3'b101, 7'b0000000, 4'b0101, 3'b000, 3'b000};
    tbl[9]  = '{2'b10, 3'b101, 7'b0100000, 4'b0100, 3'b000, 3'b000};
    tbl[10] = '{2'b10, 3'b110, 7'b0000000, 4'b0001, 3'b000, 3'b000};
    tbl[11] = '{2'b10, 3'b111, 7'b0000000, 4'b0000, 3'b000, 3'b000};
    tbl[12] = '{2'b01, 3'b000, 7'b0000000, 4'b0110, 3'b000, 3'b010};
    tbl[13] = '{2'b01, 3'b001, 7'b0000000, 4'b0110, 3'b000, 3'b001};
    tbl[14] = '{2'b01, 3'b100, 7'b0000000, 4'b1100, 3'b000, 3'b100};
    tbl[15] = '{2'b01, 3'b101, 7'b0000000, 4'b1010, 3'b000, 3'b101};
    tbl[16] = '{2'b01, 3'b110, 7'b0000000, 4'b1101, 3'b000, 3'b110};
    tbl[17] = '{2'b01, 3'b010, 7'b0000000, 4'b0000, 3'b000, 3'b000};
    tbl[18] = '{2'b00, 3'b000, 7'b0000001, 4'b0010, 3'b111, 3'b000};
    tbl[19] = '{2'b00, 3'b001, 7'b0000000, 4'b0010, 3'b001, 3'b000};
    tbl[20] = '{2'b00, 3'b010, 7'b0000000, 4'b0010, 3'b010, 3'b000};
    tbl[21] = '{2'b00, 3'b101, 7'b0000000, 4'b0010, 3'b101, 3'b000};
    tbl[22] = '{2'b00, 3'b011, 7'b0000000, 4'b0010, 3'b000, 3'b000};
    tbl[23] = '{2'b11, 3'b101, 7'b0000000, 4'b0010, 3'b000, 3'b000};
    tbl[24] = '{2'b10, 3'b000, 7'b0100001, 4'b0010, 3'b000, 3'b000};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ALUOp = '0; Funct3 = '0; Funct7 = '0;
    step();
    step();
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_state", {out_valid, Busy, Operation, Load_Type, Branch_Type, MulDiv_En, MulDiv_Op},
          32'd0);
    reset = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // back-to-back decode sweep, one vector per cycle with no bubbles
    in_valid = 1'b1;
    for (int i = 0; i < 25; i++) begin
      ALUOp  = tbl[i].aop;
      Funct3 = tbl[i].f3;
      Funct7 = tbl[i].f7;
      step();
      check($sformatf("decode_%0d", i),
            {out_valid, Operation, Load_Type, Branch_Type, MulDiv_En},
            {1'b1, tbl[i].op, tbl[i].lt, tbl[i].bt, 1'b0});
    end
    in_valid = 1'b0;
    step();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_hold_op", 32'(Operation), 32'h2);

    // DIV, latency 8
    issue(2'b10, 3'b100, 7'b0000001);
    check("base_no_mext", {b_out_valid, b_Operation, b_MulDiv_En, b_Busy}, {1'b1, 4'b0111, 1'b0, 1'b0});
    for (int i = 0; i < 8; i++) begin
      check($sformatf("div_busy_%0d", i), {Busy, in_ready, out_valid}, {1'b1, 1'b0, 1'b0});
      step();
    end
    check("div_done", {out_valid, Busy, in_ready, MulDiv_En, MulDiv_Op, Operation, Load_Type, Branch_Type},
          {1'b1, 1'b0, 1'b1, 1'b1, 3'b100, 4'b0000, 3'b000, 3'b000});
    step();
    check("div_consumed", 32'(out_valid), 32'd0);

    // MUL, latency 3
    issue(2'b10, 3'b000, 7'b0000001);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mul_busy_%0d", i), {Busy, out_valid}, {1'b1, 1'b0});
      step();
    end
    check("mul_done", {out_valid, Busy, MulDiv_En, MulDiv_Op}, {1'b1, 1'b0, 1'b1, 3'b000});
    step();

    // backpressure hold, then replacement with no bubble, then drain
    out_ready = 1'b0;
    issue(2'b01, 3'b100, 7'b0000000);
    ALUOp = 2'b10; Funct3 = 3'b110; Funct7 = 7'b0000000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold_%0d", i), {in_ready, out_valid, Operation, Load_Type, Branch_Type},
            {1'b0, 1'b1, 4'b1100, 3'b000, 3'b100});
      step();
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    step();
    check("replace", {out_valid, Operation, Branch_Type}, {1'b1, 4'b0001, 3'b000});
    in_valid = 1'b0;
    step();
    check("consume_no_accept", {out_valid, Operation}, {1'b0, 4'b0001});

    // flush during the last cycle of a MUL
    issue(2'b10, 3'b001, 7'b0000001);
    check("flush_mul_busy", 32'(Busy), 32'd1);
    step();
    step();
    flush = 1'b1;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    #1;
    check("flush_cleared", {out_valid, Busy, in_ready}, {1'b0, 1'b0, 1'b1});
    step();
    check("flush_no_late_valid", 32'(out_valid), 32'd0);

    // flush beats an accept on an idle stage
    ALUOp = 2'b00; Funct3 = 3'b010; in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_over_accept", 32'(out_valid), 32'd0);

    // reset during the last cycle of a MUL
    issue(2'b10, 3'b001, 7'b0000001);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("reset_mid_mul", {out_valid, Busy, in_ready, MulDiv_En, MulDiv_Op, Operation},
          {1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 4'b0000});
    step();
    check("reset_no_late_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_stage.md
ALU_CTRL_STAGE -- requirements
Module: alu_ctrl_stage

Interface
REQ-001 SHALL have parameter M_EXT, default 1, meaning 1 enables RV32M decode.
REQ-002 SHALL have parameter MUL_LAT, default 3, meaning MUL-family cycles from accept to out_valid (legal 1..16).
REQ-003 SHALL have parameter DIV_LAT, default 8, meaning DIV/REM-family cycles from accept to out_valid (legal 1..64).
REQ-004 SHALL have port clk  input  1  rising-edge clock; one clock domain only.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  synchronous kill of held and in-flight decode.
REQ-007 SHALL have port in_valid  input  1  decode request present.
REQ-008 SHALL have port in_ready  output  1  stage accepts a request this cycle.
REQ-009 SHALL have port ALUOp  input  2  00 load/store, 01 branch, 10 R/I-type, 11 jump/LUI/AUIPC.
REQ-010 SHALL have ports Funct7  input  7 and Funct3  input  3, instruction bits [31:25] and [14:12].
REQ-011 SHALL have port out_valid  output  1  registered decode valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts.
REQ-013 SHALL have ports Operation  output  4, Load_Type  output  3, Branch_Type  output  3, all registered.
REQ-014 SHALL have ports MulDiv_En  output  1, MulDiv_Op  output  3 (Funct3 of an M op), Busy  output  1 (multi-cycle op in flight).

Function
REQ-015 Operation SHALL encode: AND 0000, OR 0001, ADD 0010, SLL 0011, SRA 0100, SRL 0101, SUB 0110, XOR 0111, SLT 1000, SLTU 1001, BGE 1010, BGEU 1011, BLT 1100, BLTU 1101.
REQ-016 ALUOp 00 and 11 SHALL give Operation 0010; ALUOp 01 BEQ/BNE SHALL give 0110; ALUOp 10 Funct3 000 SHALL give SUB only when Funct7=0100000, else ADD; Funct3 101 SHALL give SRA when Funct7=0100000, else SRL.
REQ-017 Load_Type (ALUOp 00 only) SHALL be LB 111, LH 001, LW 010, LBU 100, LHU 101, otherwise 000.
REQ-018 Branch_Type (ALUOp 01 only) SHALL be BEQ 010, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111, otherwise 000.
REQ-019 With M_EXT=1, ALUOp 10 and Funct7=0000001 SHALL be an M op: MulDiv_En=1, MulDiv_Op=Funct3, Operation=0000, Load_Type=Branch_Type=000; with M_EXT=0 that encoding SHALL decode as a base op per REQ-016.
REQ-020 in_ready SHALL equal (!out_valid || out_ready) && !Busy && !flush.
REQ-021 Accept SHALL occur when in_valid && in_ready; a non-M accept SHALL set out_valid with its decode on the next edge (latency 1).
REQ-022 An M accept SHALL latch its decode, set Busy, and load a down-counter with LAT-1 (Funct3[2]=0 MUL_LAT, else DIV_LAT); out_valid SHALL rise exactly LAT cycles after the accept edge, and Busy SHALL clear on that same edge.
REQ-023 LAT=1 SHALL behave as a non-M accept (Busy never asserts).
REQ-024 out_valid and all output fields SHALL hold stable while out_valid && !out_ready.
REQ-025 out_valid && out_ready with a simultaneous accept SHALL replace the output with the new decode with no bubble.
REQ-026 out_valid && out_ready with no accept SHALL clear out_valid on the next edge; fields SHALL hold their last value.
REQ-027 flush SHALL, on the next edge, clear out_valid, Busy and the counter; flush SHALL take priority over accept and over counter expiry in the same cycle.
REQ-028 Unlisted Funct3/ALUOp combinations SHALL decode to Operation 0000 with zero Load_Type/Branch_Type, never X.

Reset
REQ-029 reset SHALL, on the next clk edge, force out_valid=0, Busy=0, counter=0 and Operation, Load_Type, Branch_Type, MulDiv_Op=0, MulDiv_En=0.
REQ-030 reset SHALL take priority over flush, accept and counter expiry; in_ready SHALL be 0 while reset is high, and an op in flight at reset SHALL be discarded.

Structure
REQ-031 Operation, Load_Type and Branch_Type encodings and ALUOp class values SHALL be constants/typedefs in shared package alu_ctrl_pkg, also used by the ALU and branch unit.
REQ-032 Combinational decode SHALL be a single sub-module alu_decode; alu_ctrl_stage SHALL hold only the handshake, output register and latency counter.
REQ-033 Counter width SHALL be $clog2(max(MUL_LAT,DIV_LAT)+1).

Verification
REQ-034 ALUOp=10, F3=000, F7=0100000, in_valid, out_ready=1 -> next cycle out_valid=1, Operation=0110.
REQ-035 ALUOp=00, F3=100 then ALUOp=01, F3=111 back-to-back, out_ready=1 -> Load_Type=100 then Branch_Type=111, Operation=1011, no bubble.
REQ-036 M op F7=0000001, F3=100 (DIV), DIV_LAT=8 -> Busy=1 and in_ready=0 for 8 cycles, out_valid rises on the 8th edge, MulDiv_Op=100.
REQ-037 out_ready=0 for 5 cycles with out_valid=1 -> fields stable, in_ready=0; out_ready=1 with a new request -> replacement next edge.
REQ-038 flush (then, separately, reset) at cycle 3 of a MUL, MUL_LAT=3 -> out_valid stays 0, Busy=0 next edge, in_ready=1 the following cycle.
